phase_sequencer: RTL and testbench

- Sits directly downstream of the Programmer stage and closes its loop. Consumes its phaser_plus request, {in1,in2} command and diode value.
- Owns the phase counter that is fed back to the Programmer as phaser.
- Commits each phase's confirmed 4-bit value into a per-phase register bank and flags when all phases are programmed.

---
 rtl/phase_sequencer_if.sv | 45 ++++
 rtl/phase_sequencer.sv | 172 +++++++++++++++++
 tb/tb_phase_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequencer_if
//  Description : Bundle between the Programmer stage and the phase
//                sequencer. The Programmer (master) drives the advance
//                request, the {in1,in2} command and the diode value; the
//                sequencer (slave) returns the phase index, the committed
//                register bank and its status pulses.
//  Signals     : phase_adv    - advance request level (async to clk)
//                cmd          - {in1,in2}: 11 info, 01 confirm, 00 end phase
//                diode        - data value offered for the current phase
//                phaser       - current phase index
//                prog_data    - committed slots, slot k at [k*DATA_W +: DATA_W]
//                commit_valid - one-cycle pulse per slot write
//                phase_done   - one-cycle pulse per phase advance
//                all_done     - level, every phase programmed
//                err          - one-cycle pulse, advance without confirm
//  Revision    : 1.0 - initial release
// ============================================================================
interface phase_sequencer_if #(
  parameter int NUM_PHASES = 4,
  parameter int DATA_W     = 4,
  parameter int PHASE_W    = 3
);
  logic                         phase_adv;
  logic [1:0]                   cmd;
  logic [DATA_W-1:0]            diode;
  logic [PHASE_W-1:0]           phaser;
  logic [NUM_PHASES*DATA_W-1:0] prog_data;
  logic                         commit_valid;
  logic                         phase_done;
  logic                         all_done;
  logic                         err;

  modport master (
    output phase_adv, cmd, diode,
    input  phaser, prog_data, commit_valid, phase_done, all_done, err
  );

  modport slave (
    input  phase_adv, cmd, diode,
    output phaser, prog_data, commit_valid, phase_done, all_done, err
  );
endinterface
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequencer
//  Description : Closes the Programmer loop. Synchronises the Programmer's
//                advance request, command and diode value, commits each
//                confirmed value into a per-phase register bank, owns the
//                phase counter fed back as phaser, and flags when every
//                phase has been programmed.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - phase_sequencer_if.slave (see interface header)
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int DATA_W     = 4,
  parameter int PHASE_W    = 3
) (
  input  wire logic          clk,
  input  wire logic          rst,
  phase_sequencer_if.slave   bus
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [1:0]         CMD_CONF   = 2'b01;

  typedef enum logic [0:0] {
    PROG = 1'b0,
    DONE = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronisers. diode travels alongside cmd so that the value
  // committed is the one the Programmer presented with the confirm.
  // --------------------------------------------------------------------------
  logic              adv_s1, adv_s2, adv_prev;
  logic [1:0]        cmd_s1, cmd_s2;
  logic              conf_prev;
  logic [DATA_W-1:0] diode_s1, diode_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      adv_s1    <= 1'b0;
      adv_s2    <= 1'b0;
      adv_prev  <= 1'b0;
      cmd_s1    <= 2'b00;
      cmd_s2    <= 2'b00;
      conf_prev <= 1'b0;
      diode_s1  <= '0;
      diode_s2  <= '0;
    end else begin
      adv_s1    <= bus.phase_adv;
      adv_s2    <= adv_s1;
      adv_prev  <= adv_s2;
      cmd_s1    <= bus.cmd;
      cmd_s2    <= cmd_s1;
      conf_prev <= (cmd_s2 == CMD_CONF);
      diode_s1  <= bus.diode;
      diode_s2  <= diode_s1;
    end
  end

  logic adv_edge, conf_edge;
  assign adv_edge  = adv_s2 & ~adv_prev;
  assign conf_edge = (cmd_s2 == CMD_CONF) & ~conf_prev;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t                       state, state_n;
  logic [PHASE_W-1:0]           phaser_q, phaser_n;
  logic [NUM_PHASES-1:0]        confirmed, confirmed_n;
  logic [NUM_PHASES*DATA_W-1:0] prog_q, prog_n;
  logic                         commit_q, commit_n;
  logic                         done_q, done_n;
  logic                         all_done_q, all_done_n;
  logic                         err_q, err_n;
  logic                         cur_conf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PROG;
      phaser_q   <= '0;
      confirmed  <= '0;
      prog_q     <= '0;
      commit_q   <= 1'b0;
      done_q     <= 1'b0;
      all_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      phaser_q   <= phaser_n;
      confirmed  <= confirmed_n;
      prog_q     <= prog_n;
      commit_q   <= commit_n;
      done_q     <= done_n;
      all_done_q <= all_done_n;
      err_q      <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    phaser_n    = phaser_q;
    confirmed_n = confirmed;
    prog_n      = prog_q;
    commit_n    = 1'b0;
    done_n      = 1'b0;
    all_done_n  = all_done_q;
    err_n       = 1'b0;
    cur_conf    = 1'b0;

    case (state)
      PROG: begin
        // Commit is applied before the advance is judged, so a confirm
        // arriving with the advance request lets that advance succeed.
        if (conf_edge) begin
          for (int k = 0; k < NUM_PHASES; k++) begin
            if (phaser_q == PHASE_W'(k)) begin
              prog_n[k*DATA_W +: DATA_W] = diode_s2;
              confirmed_n[k]             = 1'b1;
            end
          end
          commit_n = 1'b1;
        end

        for (int k = 0; k < NUM_PHASES; k++) begin
          if (phaser_q == PHASE_W'(k)) begin
            cur_conf = confirmed_n[k];
          end
        end

        if (adv_edge) begin
          if (!cur_conf) begin
            err_n = 1'b1;
          end else if (phaser_q == LAST_PHASE) begin
            state_n    = DONE;
            all_done_n = 1'b1;
            done_n     = 1'b1;
          end else begin
            phaser_n = phaser_q + 1'b1;
            done_n   = 1'b1;
          end
        end
      end

      DONE: begin
        // Confirms are ignored here; the bank keeps its contents across
        // the restart and is only overwritten by later commits.
        if (adv_edge) begin
          state_n     = PROG;
          phaser_n    = '0;
          confirmed_n = '0;
          all_done_n  = 1'b0;
        end
      end

      default: begin
        state_n = PROG;
      end
    endcase
  end

  assign bus.phaser       = phaser_q;
  assign bus.prog_data    = prog_q;
  assign bus.commit_valid = commit_q;
  assign bus.phase_done   = done_q;
  assign bus.all_done     = all_done_q;
  assign bus.err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_sequencer
//  Description : Directed self-checking bench for phase_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;

  localparam int NUM_PHASES = 4;
  localparam int DATA_W     = 4;
  localparam int PHASE_W    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  phase_sequencer_if #(
    .NUM_PHASES (NUM_PHASES),
    .DATA_W     (DATA_W),
    .PHASE_W    (PHASE_W)
  ) bus ();

  phase_sequencer #(
    .NUM_PHASES (NUM_PHASES),
    .DATA_W     (DATA_W),
    .PHASE_W    (PHASE_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_commit = 0;
  int n_done   = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_commit = 0;
    n_done   = 0;
    n_err    = 0;
  endtask

  // Run n cycles while tallying output pulses.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.commit_valid) n_commit++;
      if (bus.phase_done)   n_done++;
      if (bus.err)          n_err++;
    end
  endtask

  // Confirm value v in the current phase, then return cmd to 00.
  task automatic confirm(input logic [3:0] v);
    bus.diode = v;
    bus.cmd   = 2'b01;
    idle(4);
    bus.cmd   = 2'b00;
    idle(3);
  endtask

  task automatic advance();
    bus.phase_adv = 1'b1;
    idle(4);
    bus.phase_adv = 1'b0;
    idle(3);
  endtask

  initial begin
    bus.phase_adv = 1'b0;
    bus.cmd       = 2'b00;
    bus.diode     = 4'h0;

    // Reset and idle
    tick(); tick();
    rst = 1'b0;
    clr_counts();
    idle(5);
    chk("reset_phaser", 32'(bus.phaser), 32'd0);
    chk("reset_prog_data", 32'(bus.prog_data), 32'h0);
    chk("reset_all_done", 32'(bus.all_done), 32'd0);
    chk("reset_pulses", 32'(n_commit + n_done + n_err), 32'd0);

    // Phase 0: info then confirm A, exact latency of commit
    bus.diode = 4'hA;
    bus.cmd   = 2'b11;
    idle(4);
    chk("info_no_commit", 32'(n_commit), 32'd0);
    bus.cmd = 2'b01;
    tick(); tick();
    chk("commit_lat_early", 32'(bus.commit_valid), 32'd0);
    tick();
    chk("commit_lat_3", 32'(bus.commit_valid), 32'd1);
    chk("slot0_A", 32'(bus.prog_data[3:0]), 32'hA);
    tick();
    chk("commit_one_cycle", 32'(bus.commit_valid), 32'd0);
    bus.cmd = 2'b00;
    idle(3);

    // Advance from phase 0, exact latency, held level gives one advance
    bus.phase_adv = 1'b1;
    tick(); tick();
    chk("adv_lat_phaser_early", 32'(bus.phaser), 32'd0);
    tick();
    chk("adv_phase_done", 32'(bus.phase_done), 32'd1);
    chk("adv_phaser_1", 32'(bus.phaser), 32'd1);
    clr_counts();
    idle(6);
    chk("adv_held_single", 32'(n_done), 32'd0);
    chk("adv_held_phaser", 32'(bus.phaser), 32'd1);
    bus.phase_adv = 1'b0;
    idle(3);

    // Phase 1 advance without confirm -> err
    clr_counts();
    advance();
    chk("noconf_err", 32'(n_err), 32'd1);
    chk("noconf_no_done", 32'(n_done), 32'd0);
    chk("noconf_phaser", 32'(bus.phaser), 32'd1);
    chk("noconf_slot1", 32'(bus.prog_data[7:4]), 32'h0);

    // Two confirms overwrite
    clr_counts();
    confirm(4'h5);
    confirm(4'h6);
    chk("reconf_commits", 32'(n_commit), 32'd2);
    chk("reconf_slot1", 32'(bus.prog_data[7:4]), 32'h6);

    // Confirm and advance on the same edge
    bus.diode     = 4'h6;
    bus.cmd       = 2'b01;
    bus.phase_adv = 1'b1;
    tick(); tick(); tick();
    chk("same_edge_commit", 32'(bus.commit_valid), 32'd1);
    chk("same_edge_done", 32'(bus.phase_done), 32'd1);
    chk("same_edge_phaser", 32'(bus.phaser), 32'd2);
    bus.cmd       = 2'b00;
    bus.phase_adv = 1'b0;
    idle(4);

    // Phases 2 and 3 -> DONE
    confirm(4'h3);
    advance();
    chk("phase3_phaser", 32'(bus.phaser), 32'd3);
    confirm(4'hC);
    clr_counts();
    advance();
    chk("done_phase_done", 32'(n_done), 32'd1);
    chk("done_all_done", 32'(bus.all_done), 32'd1);
    chk("done_phaser", 32'(bus.phaser), 32'd3);
    chk("done_prog_data", 32'(bus.prog_data), 32'hC36A);

    // Confirm in DONE is ignored
    clr_counts();
    confirm(4'hF);
    chk("done_conf_ignored", 32'(n_commit), 32'd0);
    chk("done_conf_data", 32'(bus.prog_data), 32'hC36A);

    // Restart
    advance();
    chk("restart_phaser", 32'(bus.phaser), 32'd0);
    chk("restart_all_done", 32'(bus.all_done), 32'd0);
    chk("restart_data_kept", 32'(bus.prog_data), 32'hC36A);

    // Restarted run needs fresh confirms
    clr_counts();
    advance();
    chk("restart_needs_conf", 32'(n_err), 32'd1);

    // Reach phase 2, then reset on the same edge as a conf_edge
    confirm(4'h1);
    advance();
    confirm(4'h2);
    advance();
    chk("pre_rst_phaser", 32'(bus.phaser), 32'd2);
    bus.diode = 4'h9;
    bus.cmd   = 2'b01;
    tick(); tick();
    rst     = 1'b1;
    bus.cmd = 2'b00;
    tick();
    chk("rst_phaser", 32'(bus.phaser), 32'd0);
    chk("rst_prog_data", 32'(bus.prog_data), 32'h0);
    chk("rst_commit", 32'(bus.commit_valid), 32'd0);
    chk("rst_all_done", 32'(bus.all_done), 32'd0);
    rst = 1'b0;
    clr_counts();
    idle(5);
    chk("post_rst_quiet", 32'(n_commit + n_done + n_err), 32'd0);
    chk("post_rst_data", 32'(bus.prog_data), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
